// File: rtl/hsv_led_driver.sv
// ---------------------------------------------------------------------------
// hsv_led_driver
// Decodes the mode word from the button selector into hue/saturation/value
// register updates, converts HSV to 8-bit RGB duties with a small sequential
// datapath, and drives three active-high PWM LED outputs.
//
// Ports:
//    clk                  system clock
//    reset                asynchronous active-high reset
//    sost[3:0]            mode from the selector (0..6 meaningful, 7..15 hold)
//    h[8:0], s[6:0], v[6:0]   hue / saturation / value setpoints
//    hue[8:0], sat[6:0], val[6:0]   current HSV registers
//    duty_r/g/b[7:0]      active duties, updated only at a PWM counter wrap
//    led_r/g/b            PWM outputs, high while counter < duty
//
// Optional build macro: HSV_LED_GAMMA_EN -- square-law gamma on each channel
// (x*x/255) before it is loaded into the duty register.
// ---------------------------------------------------------------------------
module hsv_led_driver #(
   parameter int unsigned STEP_TICKS = 1000000,
   parameter int unsigned PWM_DIV    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] sost,
   input  logic [8:0] h,
   input  logic [6:0] s,
   input  logic [6:0] v,
   output logic [8:0] hue,
   output logic [6:0] sat,
   output logic [6:0] val,
   output logic [7:0] duty_r,
   output logic [7:0] duty_g,
   output logic [7:0] duty_b,
   output logic       led_r,
   output logic       led_g,
   output logic       led_b
);

   localparam int unsigned TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
   localparam int unsigned PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_WAIT} state_t;

`ifdef HSV_LED_GAMMA_EN
   function automatic logic [7:0] f_gamma(input logic [7:0] x);
      return 8'((16'(x) * 16'(x)) / 16'd255);
   endfunction
`else
   function automatic logic [7:0] f_gamma(input logic [7:0] x);
      return x;
   endfunction
`endif

   // ---------------- mode tick ----------------
   logic [3:0]    r_sost_q;
   logic [TW-1:0] r_tick_cnt;
   logic          w_sost_chg;
   logic          w_tick_end;
   logic          w_tick;

   assign w_sost_chg = (sost != r_sost_q);
   assign w_tick_end = (r_tick_cnt == TW'(STEP_TICKS - 1));
   // a mode change wins over a coincident tick
   assign w_tick     = w_tick_end && !w_sost_chg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sost_q   <= '0;
         r_tick_cnt <= '0;
      end else begin
         r_sost_q <= sost;
         if (w_sost_chg || w_tick_end)
            r_tick_cnt <= '0;
         else
            r_tick_cnt <= r_tick_cnt + TW'(1);
      end
   end

   // ---------------- HSV registers ----------------
   logic [8:0] r_hue;
   logic [6:0] r_sat;
   logic [6:0] r_val;
   logic [9:0] w_hue_sum;
   logic [9:0] w_hue_wrap;

   always_comb begin
      w_hue_sum  = {1'b0, r_hue} + ((sost == 4'd1) ? 10'd60 : 10'd1);
      w_hue_wrap = (w_hue_sum >= 10'd360) ? (w_hue_sum - 10'd360) : w_hue_sum;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hue <= '0;
         r_sat <= 7'd100;
         r_val <= 7'd100;
      end else begin
         case (sost)
            4'd0:       r_hue <= 9'd120;
            4'd1, 4'd2: if (w_tick) r_hue <= w_hue_wrap[8:0];
            4'd3:       r_hue <= (h > 9'd359) ? 9'd359 : h;
            4'd4:       r_val <= (v > 7'd100) ? 7'd100 : v;
            4'd5:       r_sat <= (s > 7'd100) ? 7'd100 : s;
            4'd6: begin
               r_sat <= 7'd50;
               r_val <= 7'd50;
            end
            default: ;
         endcase
      end
   end

   // ---------------- PWM counter ----------------
   logic [PW-1:0] r_pre;
   logic [7:0]    r_cnt;
   logic          w_pstep;
   logic          w_wrap;

   assign w_pstep = (r_pre == PW'(PWM_DIV - 1));
   assign w_wrap  = w_pstep && (r_cnt == 8'd254);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pre <= '0;
         r_cnt <= '0;
      end else if (w_pstep) begin
         r_pre <= '0;
         r_cnt <= (r_cnt == 8'd254) ? 8'd0 : r_cnt + 8'd1;
      end else begin
         r_pre <= r_pre + PW'(1);
      end
   end

   // ---------------- conversion FSM ----------------
   state_t r_state;
   state_t w_state_nxt;
   logic   w_snap;
   logic   w_load;
   logic [1:0] r_step;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // WAIT loads duties and snapshots in the same wrap cycle, so it passes
   // through IDLE implicitly and enters CALC directly.
   always_comb begin
      w_state_nxt = r_state;
      w_snap      = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: if (w_wrap) begin
            w_state_nxt = ST_CALC;
            w_snap      = 1'b1;
         end
         ST_CALC: if (r_step == 2'd3) w_state_nxt = ST_WAIT;
         ST_WAIT: if (w_wrap) begin
            w_state_nxt = ST_CALC;
            w_snap      = 1'b1;
            w_load      = 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- conversion datapath ----------------
   logic [8:0] r_hue_s;
   logic [6:0] r_sat_s;
   logic [6:0] r_val_s;
   logic [7:0] r_vmax, r_vmin, r_d;
   logic [2:0] r_sec;
   logic [5:0] r_f;
   logic [7:0] r_r, r_g, r_b;
   logic [7:0] r_duty_r, r_duty_g, r_duty_b;
   logic [7:0] w_rise, w_fall;

   assign w_rise = r_vmin + r_d;
   assign w_fall = r_vmax - r_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hue_s  <= '0;
         r_sat_s  <= '0;
         r_val_s  <= '0;
         r_step   <= '0;
         r_vmax   <= '0;
         r_vmin   <= '0;
         r_d      <= '0;
         r_sec    <= '0;
         r_f      <= '0;
         r_r      <= '0;
         r_g      <= '0;
         r_b      <= '0;
         r_duty_r <= '0;
         r_duty_g <= '0;
         r_duty_b <= '0;
      end else begin
         if (w_snap) begin
            r_hue_s <= r_hue;
            r_sat_s <= r_sat;
            r_val_s <= r_val;
            r_step  <= '0;
         end else if (r_state == ST_CALC) begin
            r_step <= r_step + 2'd1;
            case (r_step)
               2'd0: begin
                  r_vmax <= 8'((16'(r_val_s) * 16'd255) / 16'd100);
                  r_sec  <= 3'(r_hue_s / 9'd60);
                  r_f    <= 6'(r_hue_s % 9'd60);
               end
               2'd1: r_vmin <= 8'((16'(r_vmax) * 16'(7'd100 - r_sat_s)) / 16'd100);
               2'd2: r_d    <= 8'((16'(r_vmax - r_vmin) * 16'(r_f)) / 16'd60);
               default: begin
                  case (r_sec)
                     3'd0:    begin r_r <= r_vmax; r_g <= w_rise; r_b <= r_vmin; end
                     3'd1:    begin r_r <= w_fall; r_g <= r_vmax; r_b <= r_vmin; end
                     3'd2:    begin r_r <= r_vmin; r_g <= r_vmax; r_b <= w_rise; end
                     3'd3:    begin r_r <= r_vmin; r_g <= w_fall; r_b <= r_vmax; end
                     3'd4:    begin r_r <= w_rise; r_g <= r_vmin; r_b <= r_vmax; end
                     default: begin r_r <= r_vmax; r_g <= r_vmin; r_b <= w_fall; end
                  endcase
               end
            endcase
         end
         if (w_load) begin
            r_duty_r <= f_gamma(r_r);
            r_duty_g <= f_gamma(r_g);
            r_duty_b <= f_gamma(r_b);
         end
      end
   end

   // ---------------- outputs ----------------
   assign hue    = r_hue;
   assign sat    = r_sat;
   assign val    = r_val;
   assign duty_r = r_duty_r;
   assign duty_g = r_duty_g;
   assign duty_b = r_duty_b;
   assign led_r  = (r_cnt < r_duty_r);
   assign led_g  = (r_cnt < r_duty_g);
   assign led_b  = (r_cnt < r_duty_b);

endmodule

// File: tb/tb_hsv_led_driver.sv
// ---------------------------------------------------------------------------
// tb_hsv_led_driver
// Self-checking bench for hsv_led_driver: table-driven mode-decode vectors,
// randomized HSV conversion against a reference model, and hand-written
// sequences for hue wrap, tick timing, zero value and reset mid-conversion.
// ---------------------------------------------------------------------------
module tb_hsv_led_driver;

   localparam int unsigned STEP   = 100;
   localparam int unsigned DIV    = 2;
   localparam int unsigned PER    = 255 * DIV;
   localparam int unsigned SETTLE = 2 * PER + 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] sost;
   logic [8:0] h;
   logic [6:0] s;
   logic [6:0] v;
   logic [8:0] hue;
   logic [6:0] sat;
   logic [6:0] val;
   logic [7:0] duty_r, duty_g, duty_b;
   logic       led_r, led_g, led_b;

   int checks = 0;
   int errors = 0;

   int m_hue, m_sat, m_val;

   typedef struct {
      int md; int hh; int ss; int vv;
      int eh; int es; int ev;
   } vec_t;
   vec_t tbl[14];

   always #5 clk = ~clk;

   hsv_led_driver #(.STEP_TICKS(STEP), .PWM_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .sost(sost), .h(h), .s(s), .v(v),
      .hue(hue), .sat(sat), .val(val),
      .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
      .led_r(led_r), .led_g(led_g), .led_b(led_b)
   );

   task automatic step(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int clampi(input int x, input int hi);
      return (x > hi) ? hi : x;
   endfunction

   function automatic int ref_gamma(input int x);
`ifdef HSV_LED_GAMMA_EN
      return (x * x) / 255;
`else
      return x;
`endif
   endfunction

   // HSV -> RGB with plain integer arithmetic
   task automatic ref_rgb(input int hh, input int ss, input int vv,
                          output int r, output int g, output int b);
      int vmax, vmin, sector, f, d, rise, fall;
      int lvl[3];
      vmax   = vv * 255 / 100;
      vmin   = vmax * (100 - ss) / 100;
      sector = hh / 60;
      f      = hh - 60 * sector;
      d      = (vmax - vmin) * f / 60;
      rise   = vmin + d;
      fall   = vmax - d;
      case (sector)
         0: lvl = '{vmax, rise, vmin};
         1: lvl = '{fall, vmax, vmin};
         2: lvl = '{vmin, vmax, rise};
         3: lvl = '{vmin, fall, vmax};
         4: lvl = '{rise, vmin, vmax};
         default: lvl = '{vmax, vmin, fall};
      endcase
      r = ref_gamma(lvl[0]);
      g = ref_gamma(lvl[1]);
      b = ref_gamma(lvl[2]);
   endtask

   task automatic model_mode(input int md, input int hh, input int ss, input int vv);
      case (md)
         0: m_hue = 120;
         3: m_hue = clampi(hh, 359);
         4: m_val = clampi(vv, 100);
         5: m_sat = clampi(ss, 100);
         6: begin m_sat = 50; m_val = 50; end
         default: ;
      endcase
   endtask

   task automatic check_duty(input string name, input int hh, input int ss, input int vv);
      int er, eg, eb;
      ref_rgb(hh, ss, vv, er, eg, eb);
      check({name, ".duty_r"}, int'(duty_r), er);
      check({name, ".duty_g"}, int'(duty_g), eg);
      check({name, ".duty_b"}, int'(duty_b), eb);
   endtask

   task automatic apply(input int md, input int hh, input int ss, input int vv);
      sost = 4'(md);
      h    = 9'(hh);
      s    = 7'(ss);
      v    = 7'(vv);
      step(1);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int bad_r, bad_g, bad_b;
      int fh[2], fs[2], fv[2];
      int hh, ss, vv;

      tbl[0]  = '{0,  17,   3,   9, 120, 100, 100};
      tbl[1]  = '{3, 400,   3,   9, 359, 100, 100};
      tbl[2]  = '{3,  45,   3,   9,  45, 100, 100};
      tbl[3]  = '{4,  45,   3, 127,  45, 100, 100};
      tbl[4]  = '{4,  45,   3,  37,  45, 100,  37};
      tbl[5]  = '{5,  45,   0,  37,  45,   0,  37};
      tbl[6]  = '{5,  45, 101,  37,  45, 100,  37};
      tbl[7]  = '{6,  45, 101,  37,  45,  50,  50};
      tbl[8]  = '{9,  10,   3,   4,  45,  50,  50};
      tbl[9]  = '{15, 10,   3,   4,  45,  50,  50};
      tbl[10] = '{5, 300,  77,   1,  45,  77,  50};
      tbl[11] = '{3, 359,  77,   1, 359,  77,  50};
      tbl[12] = '{4,   0,   0, 100, 359,  77, 100};
      tbl[13] = '{3,   0,   0,   0,   0,  77, 100};

      reset = 1'b1; sost = '0; h = '0; s = '0; v = '0;
      step(2);
      check("rst.hue", int'(hue), 0);
      check("rst.sat", int'(sat), 100);
      check("rst.val", int'(val), 100);
      check("rst.duty", int'({duty_r, duty_g, duty_b}), 0);
      check("rst.leds", int'({led_r, led_g, led_b}), 0);
      reset = 1'b0;

      // mode 0: pure green, led_g always on
      apply(0, 0, 0, 0);
      step(SETTLE);
      check("m0.hue", int'(hue), 120);
      check_duty("m0", 120, 100, 100);
      bad_r = 0; bad_g = 0; bad_b = 0;
      for (int i = 0; i < int'(PER); i++) begin
         step(1);
         if (led_r !== 1'b0) bad_r++;
         if (led_g !== 1'b1) bad_g++;
         if (led_b !== 1'b0) bad_b++;
      end
      check("m0.led_r_high_cycles", bad_r, 0);
      check("m0.led_g_low_cycles", bad_g, 0);
      check("m0.led_b_high_cycles", bad_b, 0);

      // table of single-cycle decode vectors
      for (int i = 0; i < 14; i++) begin
         apply(tbl[i].md, tbl[i].hh, tbl[i].ss, tbl[i].vv);
         check($sformatf("tbl[%0d].hue", i), int'(hue), tbl[i].eh);
         check($sformatf("tbl[%0d].sat", i), int'(sat), tbl[i].es);
         check($sformatf("tbl[%0d].val", i), int'(val), tbl[i].ev);
      end

      // mode 6 at hue 120
      apply(0, 0, 0, 0);
      apply(6, 0, 0, 0);
      check("m6.hsv", int'(hue) * 65536 + int'(sat) * 256 + int'(val), 120 * 65536 + 50 * 256 + 50);
      apply(7, 0, 0, 0);
      step(SETTLE);
      check_duty("m6", 120, 50, 50);

      // random decode, ticking modes excluded
      m_hue = 120; m_sat = 50; m_val = 50;
      for (int i = 0; i < 60; i++) begin
         int md;
         md = int'($urandom_range(0, 15));
         if (md == 1 || md == 2) md = 7;
         hh = int'($urandom_range(0, 511));
         ss = int'($urandom_range(0, 127));
         vv = int'($urandom_range(0, 127));
         apply(md, hh, ss, vv);
         model_mode(md, hh, ss, vv);
         check($sformatf("rnd[%0d].hsv", i), int'(hue) * 65536 + int'(sat) * 256 + int'(val),
               m_hue * 65536 + m_sat * 256 + m_val);
      end

      // randomized conversions, first two forced to sat=0 and val=0
      fh = '{200, 75}; fs = '{0, 60}; fv = '{80, 0};
      for (int i = 0; i < 8; i++) begin
         if (i < 2) begin
            hh = fh[i]; ss = fs[i]; vv = fv[i];
         end else begin
            hh = int'($urandom_range(0, 511));
            ss = int'($urandom_range(0, 127));
            vv = int'($urandom_range(0, 127));
         end
         apply(3, hh, 0, 0);
         apply(5, 0, ss, 0);
         apply(4, 0, 0, vv);
         apply(7, 0, 0, 0);
         check($sformatf("cv[%0d].hsv", i), int'(hue) * 65536 + int'(sat) * 256 + int'(val),
               clampi(hh, 359) * 65536 + clampi(ss, 100) * 256 + clampi(vv, 100));
         step(SETTLE);
         check_duty($sformatf("cv[%0d]", i), clampi(hh, 359), clampi(ss, 100), clampi(vv, 100));
      end

      // mode 2: 358 -> 359 -> 0; one cycle to register the mode, then STEP
      apply(3, 358, 0, 0);
      sost = 4'd2;
      n = 0;
      while (hue == 9'd358 && n < int'(3 * STEP)) begin step(1); n++; end
      check("m2.first_tick_cycles", n, int'(STEP) + 1);
      check("m2.hue_359", int'(hue), 359);
      n = 0;
      while (hue == 9'd359 && n < int'(3 * STEP)) begin step(1); n++; end
      check("m2.second_tick_cycles", n, int'(STEP));
      check("m2.hue_wrap0", int'(hue), 0);

      // mode 1: 330 -> 30, full sat and value
      apply(5, 0, 100, 0);
      apply(4, 0, 0, 100);
      apply(3, 330, 0, 0);
      sost = 4'd1;
      n = 0;
      while (hue == 9'd330 && n < int'(3 * STEP)) begin step(1); n++; end
      sost = 4'd7;
      check("m1.tick_cycles", n, int'(STEP) + 1);
      check("m1.hue_wrap30", int'(hue), 30);
      step(SETTLE);
      check_duty("m1", 30, 100, 100);

      // clamped hue, zero value: everything dark
      apply(3, 400, 0, 0);
      apply(4, 0, 0, 0);
      apply(7, 0, 0, 0);
      check("v0.hue", int'(hue), 359);
      check("v0.val", int'(val), 0);
      step(SETTLE);
      check("v0.duty", int'({duty_r, duty_g, duty_b}), 0);
      n = 0;
      for (int i = 0; i < int'(PER); i++) begin
         step(1);
         if ({led_r, led_g, led_b} != 3'b000) n++;
      end
      check("v0.led_high_cycles", n, 0);

      // reset during the second conversion after a clean reset
      reset = 1'b1;
      step(2);
      sost  = 4'd0;
      reset = 1'b0;
      step(2 * PER + 2);
      check("rc.pre_duty_g", int'(duty_g), ref_gamma(255));
      reset = 1'b1;
      #1;
      check("rc.duty", int'({duty_r, duty_g, duty_b}), 0);
      check("rc.hsv", int'(hue) * 65536 + int'(sat) * 256 + int'(val), 100 * 256 + 100);
      check("rc.leds", int'({led_r, led_g, led_b}), 0);
      sost = 4'd7;
      step(1);
      reset = 1'b0;
      step(SETTLE);
      check_duty("rc.post", 0, 100, 100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
